// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants and types for the writeback port arbiter.
package wb_port_arbiter_pkg;

   localparam int LOG2_MAX_IDS = 3;
   localparam int MAX_WB_UNITS = 8;

   typedef logic [$clog2(MAX_WB_UNITS)-1:0] wb_unit_idx_t;

   // Unit index width; a single unit still needs a 1-bit pointer.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/wb_port_arbiter_rr_select.sv
// Combinational round-robin multi-grant selector: rotate requests to the start
// pointer, take NUM_PORTS cascaded lowest-bit picks, rotate the grants back.
module wb_rr_select
   import wb_port_arbiter_pkg::*;
#(
   parameter  int NUM_UNITS = 4,
   parameter  int NUM_PORTS = 2,
   localparam int IDX_W     = idx_w(NUM_UNITS)
) (
   input  logic [NUM_UNITS-1:0]                 i_req,
   input  logic [IDX_W-1:0]                     i_start,
   output logic [NUM_UNITS-1:0]                 o_grant,
   output logic [NUM_PORTS-1:0][IDX_W-1:0]      o_port_idx,
   output logic [NUM_PORTS-1:0]                 o_port_valid,
   output logic [IDX_W-1:0]                     o_last_idx
);

   localparam int SUM_W = IDX_W + 1;

   logic [2*NUM_UNITS-1:0]            w_req_dbl;
   logic [2*NUM_UNITS-1:0]            w_grant_dbl;
   logic [NUM_UNITS-1:0]              w_rot;
   logic [NUM_UNITS-1:0]              w_rem;
   logic [NUM_UNITS-1:0]              w_pick;
   logic [NUM_UNITS-1:0]              w_grant_rot;
   logic [NUM_PORTS-1:0][IDX_W-1:0]   w_rot_idx;
   logic [SUM_W-1:0]                  w_sum;

   assign w_req_dbl = {i_req, i_req} >> i_start;
   assign w_rot     = w_req_dbl[NUM_UNITS-1:0];

   // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      w_rem        = w_rot;
      w_pick       = '0;
      w_grant_rot  = '0;
      w_rot_idx    = '0;
      o_port_valid = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         w_pick          = w_rem & (~w_rem + NUM_UNITS'(1));
         w_rem           = w_rem & ~w_pick;
         w_grant_rot     = w_grant_rot | w_pick;
         o_port_valid[p] = |w_pick;
         for (int i = 0; i < NUM_UNITS; i++)
            if (w_pick[i]) w_rot_idx[p] = IDX_W'(i);
      end
   end

   assign w_grant_dbl = {w_grant_rot, w_grant_rot} << i_start;
   assign o_grant     = w_grant_dbl[2*NUM_UNITS-1:NUM_UNITS];

   // Map rotated positions back to absolute unit indices, mod NUM_UNITS.
   always_comb begin
      o_port_idx = '0;
      o_last_idx = '0;
      w_sum      = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         w_sum = SUM_W'(w_rot_idx[p]) + SUM_W'(i_start);
         if (w_sum >= SUM_W'(NUM_UNITS)) w_sum = w_sum - SUM_W'(NUM_UNITS);
         o_port_idx[p] = w_sum[IDX_W-1:0];
         if (o_port_valid[p]) o_last_idx = w_sum[IDX_W-1:0];
      end
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Writeback arbiter: grants up to NUM_PORTS of NUM_UNITS packets per cycle onto
// registered ports, round-robin. Define WB_ARB_STATS_EN to build contention_count.
module wb_port_arbiter
   import wb_port_arbiter_pkg::*;
#(
   parameter int NUM_UNITS = 4,
   parameter int NUM_PORTS = 2,
   parameter int DATA_W    = 32,
   parameter int ID_W      = LOG2_MAX_IDS
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               suppress,
   input  logic [NUM_UNITS-1:0]               unit_valid,
   input  logic [NUM_UNITS-1:0][ID_W-1:0]     unit_id,
   input  logic [NUM_UNITS-1:0][DATA_W-1:0]   unit_data,
   output logic [NUM_UNITS-1:0]               unit_ack,
   output logic [NUM_PORTS-1:0]               wb_valid,
   output logic [NUM_PORTS-1:0][ID_W-1:0]     wb_id,
   output logic [NUM_PORTS-1:0][DATA_W-1:0]   wb_data,
   output logic [31:0]                        contention_count
);

   localparam int IDX_W = idx_w(NUM_UNITS);

   logic [IDX_W-1:0]                    r_ptr;
   logic [NUM_PORTS-1:0]                r_wb_valid;
   logic [NUM_PORTS-1:0][ID_W-1:0]      r_wb_id;
   logic [NUM_PORTS-1:0][DATA_W-1:0]    r_wb_data;

   logic [NUM_UNITS-1:0]                w_req;
   logic [NUM_UNITS-1:0]                w_grant;
   logic [NUM_PORTS-1:0][IDX_W-1:0]     w_port_idx;
   logic [NUM_PORTS-1:0]                w_port_valid;
   logic [IDX_W-1:0]                    w_last_idx;

   // Masking requests makes reset and suppress yield no grants and no pointer move.
   assign w_req = unit_valid & {NUM_UNITS{~(rst | suppress)}};

   wb_rr_select #(
      .NUM_UNITS (NUM_UNITS),
      .NUM_PORTS (NUM_PORTS)
   ) u_select (
      .i_req        (w_req),
      .i_start      (r_ptr),
      .o_grant      (w_grant),
      .o_port_idx   (w_port_idx),
      .o_port_valid (w_port_valid),
      .o_last_idx   (w_last_idx)
   );

   assign unit_ack = w_grant;
   assign wb_valid = r_wb_valid;
   assign wb_id    = r_wb_id;
   assign wb_data  = r_wb_data;

   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr      <= '0;
         r_wb_valid <= '0;
         // NOTE: the port id/data registers are reset too, since consumers see zeros during reset.
         r_wb_id    <= '0;
         r_wb_data  <= '0;
      end else begin
         r_wb_valid <= w_port_valid;
         if (|w_grant)
            r_ptr <= (w_last_idx == IDX_W'(NUM_UNITS - 1)) ? '0 : w_last_idx + IDX_W'(1);
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_port_valid[p]) begin
               r_wb_id[p]   <= unit_id[w_port_idx[p]];
               r_wb_data[p] <= unit_data[w_port_idx[p]];
            end
         end
      end
   end

`ifdef WB_ARB_STATS_EN
   logic [31:0] r_contention;

   always_ff @(posedge clk) begin
      if (rst)
         r_contention <= '0;
      else if ((|(unit_valid & ~w_grant)) && (r_contention != '1))
         r_contention <= r_contention + 32'd1;
   end

   assign contention_count = r_contention;
`else
   assign contention_count = 32'd0;
`endif

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Parametrised writeback arbiter. Up to NUM_UNITS execution units each offer one writeback packet (id, valid, data). Per cycle, up to NUM_PORTS of them are granted onto registered writeback ports using rotating round-robin priority. It sits between the execution units and the register-file and scoreboard writeback, and generalises the single-packet wb_packet_t/fp_wb_packet_t path to arbitrary unit count, port count and data width (XLEN or FLEN).

## Interface
Parameters:
- NUM_UNITS, 4, number of requesting units; must be ≥ 1.
- NUM_PORTS, 2, number of writeback ports; must satisfy 1 ≤ NUM_PORTS ≤ NUM_UNITS.
- DATA_W, 32, writeback data width; use 32 for integer and FLEN for FP.
- ID_W, LOG2_MAX_IDS, instruction id width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- suppress  in  1  writeback suppress from gc; blocks all grants this cycle.
- unit_valid  in  NUM_UNITS  per-unit request.
- unit_id  in  NUM_UNITS×ID_W  per-unit id.
- unit_data  in  NUM_UNITS×DATA_W  per-unit result.
- unit_ack  out  NUM_UNITS  grant; the packet is consumed at this clock edge.
- wb_valid  out  NUM_PORTS  registered port valid.
- wb_id  out  NUM_PORTS×ID_W  registered port id.
- wb_data  out  NUM_PORTS×DATA_W  registered port data.
- contention_count  out  32  cycles in which at least one valid unit was not acked.

## Operation
- **Request rule.** A unit holds valid, id and data stable until it sees unit_ack. Ack is combinational from unit_valid, suppress and rr_ptr.
- **Grant search.** Start at unit rr_ptr and scan cyclically: rr_ptr, rr_ptr+1, …, wrapping mod NUM_UNITS. The first NUM_PORTS valid units found are acked.
- **Port assignment.** The k-th granted unit in scan order goes to port k. Ports above the grant count get wb_valid=0.
- **Pointer update.** If any grant occurs, rr_ptr becomes (index of the last granted unit + 1) mod NUM_UNITS. With no grants, rr_ptr is unchanged.
- **Suppress.** When suppress=1:
  - all unit_ack are 0;
  - every wb_valid is 0 in the next cycle;
  - rr_ptr holds;
  - contention is counted if any unit_valid=1.
- **Output hold.** wb_id and wb_data of an invalid port hold their previous value. Consumers must qualify with wb_valid.
- **Contention counter.** Increments by 1 in every cycle where (unit_valid & ~unit_ack) is nonzero. It saturates at 2^32-1.
- **No state machine beyond the pointer.** State is rr_ptr ($clog2(NUM_UNITS) bits, or 1 bit when NUM_UNITS=1), the port registers and the counter.

## Timing
- **Latency.** A grant at edge N produces wb_valid, wb_id and wb_data during cycle N+1, for exactly one cycle unless a new grant lands on the same port.
- **Throughput.** Up to NUM_PORTS packets per cycle with no bubbles. A unit may re-request in the cycle after its ack.
- **Reset.** While rst=1:
  - wb_valid=0, wb_id=0, wb_data=0;
  - rr_ptr=0;
  - contention_count=0;
  - unit_ack is forced to 0.
  Packets offered during reset are not consumed.
- **Reset mid-operation.** Packets granted at the reset edge are discarded. The in-flight wb_valid drops to 0 in the following cycle.
- **Simultaneous requests.** With all NUM_UNITS valid and NUM_UNITS > NUM_PORTS, every unit is granted within ceil(NUM_UNITS/NUM_PORTS) cycles.
- **Wrap-around.** Scan and pointer arithmetic are mod NUM_UNITS. With NUM_PORTS = NUM_UNITS, every valid unit is acked every cycle.

## Configuration
- **WB_ARB_STATS_EN defined:** contention_count is implemented as described.
- **WB_ARB_STATS_EN undefined:** contention_count is tied to 0, no counter register exists, and all other behaviour is identical.

## Structure
- **Shared package.** Add to cva5_types:
  - constant MAX_WB_UNITS;
  - typedef wb_unit_idx_t (logic[$clog2(MAX_WB_UNITS)-1:0]).

  The existing wb_packet_t and fp_wb_packet_t remain the per-port views for the DATA_W=32 and DATA_W=FLEN instances.
- **Sub-module wb_rr_select (combinational).**
  - Inputs: request vector, start pointer.
  - Outputs: grant vector, port-to-unit index per port, port-valid per port, last-granted index.
  - Built by rotate, then NUM_PORTS cascaded priority picks, then rotate back.
- **Top level.** Holds rr_ptr, the port registers and the optional counter.

## Test plan
- **Reset.** Hold rst=1 for 3 cycles with all unit_valid=1 → unit_ack=0 and wb_valid=0 throughout. The first cycle after release: ack=4'b0011, and ports 0/1 carry units 0/1 in the next cycle.
- **Round-robin rotation.** Defaults; all 4 units valid continuously with ids 0–3 → acks 0011, 1100, 0011, … and rr_ptr alternates 2, 0. contention_count rises by 1 per cycle (with WB_ARB_STATS_EN).
- **Sparse wrap.** rr_ptr=3; units 3 and 0 valid → both acked, port0=unit3, port1=unit0, rr_ptr becomes 1.
- **Suppress.** suppress=1 for one cycle with unit 2 valid (id=5, data=32'hDEADBEEF) → ack=0, wb_valid=0 next cycle, rr_ptr unchanged. On release, unit 2 is acked and port0 shows id 5 / DEADBEEF one cycle later.
- **Full ports.** NUM_UNITS=NUM_PORTS=3, all valid → all acked every cycle and contention_count stays 0.
- **Macro off.** Build without WB_ARB_STATS_EN and rerun the rotation scenario → identical acks and ports, contention_count constantly 0.
